sha3_padder: RTL

- Hardware front end for the `keccak` core. Replaces the byte reading and padding that is currently done in software.
- Accepts a message as a byte stream with valid/ready and a last flag.
- Packs bytes into R-bit rate blocks, first byte in the MSBs, matching the `{m[r-9:0], byte}` shift order the core consumes.
- Applies SHA-3 pad10*1 with domain byte 0x06 and hands each block to the core over a valid/ready handshake.

---
 rtl/sha3_padder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sha3_padder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sha3_padder                                                      |
// | Purpose  : Byte-stream front end for keccak: packs rate blocks, pad10*1     |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sha3_padder #(
    parameter int D     = 512,
    parameter int R     = 1600 - 2*D,
    parameter int BYTES = R/8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_keep,
    input  logic         in_last,
    output logic         in_ready,
    output logic [R-1:0] block,
    output logic         block_valid,
    output logic         block_last,
    input  logic         block_ready
);

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_PAD  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [7:0] c_LAST_IDX = 8'(BYTES - 1);

    logic [1:0]   r_state, w_state_nxt;
    logic [7:0]   r_idx, w_idx_nxt;
    logic [7:0]   r_pad_pos, w_pad_pos_nxt;
    logic         r_pad_pending, w_pad_pending_nxt;
    logic         r_block_last, w_block_last_nxt;
    logic [R-1:0] r_block, w_block_nxt;
    logic         w_accept;

    assign in_ready    = (r_state == S_FILL);
    assign block_valid = (r_state == S_HOLD);
    assign block_last  = r_block_last;
    assign block       = r_block;
    assign w_accept    = in_ready && in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FILL;
            r_idx         <= '0;
            r_pad_pos     <= '0;
            r_pad_pending <= 1'b0;
            r_block_last  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_pad_pos     <= w_pad_pos_nxt;
            r_pad_pending <= w_pad_pending_nxt;
            r_block_last  <= w_block_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_pad_pos_nxt     = r_pad_pos;
        w_pad_pending_nxt = r_pad_pending;
        w_block_last_nxt  = r_block_last;
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    if (!in_last) begin
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt      = S_HOLD;
                            w_block_last_nxt = 1'b0;
                        end else begin
                            w_idx_nxt = r_idx + 8'd1;
                        end
                    end else if (in_keep) begin
                        // A message that exactly fills the block needs a whole extra pad block.
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt       = S_HOLD;
                            w_block_last_nxt  = 1'b0;
                            w_pad_pending_nxt = 1'b1;
                        end else begin
                            w_pad_pos_nxt = r_idx + 8'd1;
                            w_state_nxt   = S_PAD;
                        end
                    end else begin
                        w_pad_pos_nxt = r_idx;
                        w_state_nxt   = S_PAD;
                    end
                end
            end
            S_PAD: begin
                w_state_nxt       = S_HOLD;
                w_block_last_nxt  = 1'b1;
                w_pad_pending_nxt = 1'b0;
            end
            S_HOLD: begin
                if (block_ready) begin
                    if (r_pad_pending) begin
                        w_pad_pos_nxt = '0;
                        w_state_nxt   = S_PAD;
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_FILL;
                    end
                end
            end
            default: begin
                w_state_nxt = S_FILL;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Byte i occupies bits [R-1-8i -: 8]; padding rewrites everything from pad_pos upward.
    always_comb begin
        w_block_nxt = r_block;
        if (w_accept && in_keep) begin
            for (int i = 0; i < BYTES; i++) begin
                if (i[7:0] == r_idx) begin
                    w_block_nxt[R-1-8*i -: 8] = in_data;
                end
            end
        end else if (r_state == S_PAD) begin
            for (int i = 0; i < BYTES; i++) begin
                if (i[7:0] == r_pad_pos) begin
                    w_block_nxt[R-1-8*i -: 8] = 8'h06;
                end else if (i[7:0] > r_pad_pos) begin
                    w_block_nxt[R-1-8*i -: 8] = 8'h00;
                end
            end
            w_block_nxt[7] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_block <= '0;
        end else begin
            r_block <= w_block_nxt;
        end
    end

endmodule
`default_nettype wire
